// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS anodes with an
// anti-ghost blanking gap per slot, optional hex decode and per-digit blink.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    hex_mode,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp_n
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  BLANK_LIM  = SCAN_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic [NUM_DIGITS-1:0] an_p0;
    logic [6:0]            seg_p0;
    logic                  dp_n_p0;
    logic [3:0]            nib_p0;
    logic                  dp_bit_p0;
    logic                  mask_bit_p0;
    logic                  gap_p0;
    logic                  blink_off_p0;

    // Active-low segment pattern {a,b,c,d,e,f,g}; 10-15 dark unless hex_mode.
    function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b000_0001;
            4'h1:    s = 7'b100_1111;
            4'h2:    s = 7'b001_0010;
            4'h3:    s = 7'b000_0110;
            4'h4:    s = 7'b100_1100;
            4'h5:    s = 7'b010_0100;
            4'h6:    s = 7'b010_0000;
            4'h7:    s = 7'b000_1111;
            4'h8:    s = 7'b000_0000;
            4'h9:    s = 7'b000_0100;
            4'hA:    s = 7'b000_1000;
            4'hB:    s = 7'b110_0000;
            4'hC:    s = 7'b011_0001;
            4'hD:    s = 7'b100_0010;
            4'hE:    s = 7'b011_0000;
            default: s = 7'b011_1000;
        endcase
        if (!hex && (v > 4'd9)) begin
            s = SEG_OFF;
        end
        return s;
    endfunction

    // Slot timer and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink timer; cleared immediately when blinking is switched off so the
    // digits come back on the very next registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Stage p0: select the active digit and form the next output pattern
    always_comb begin
        nib_p0      = 4'h0;
        dp_bit_p0   = 1'b0;
        mask_bit_p0 = 1'b0;
        an_p0       = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_p0      = digits[4*i +: 4];
                dp_bit_p0   = dp_in[i];
                mask_bit_p0 = blink_mask[i];
                an_p0[i]    = 1'b0;
            end
        end

        gap_p0       = (scan_cnt < BLANK_LIM);
        blink_off_p0 = blink_en && blink_phase && mask_bit_p0;

        if (gap_p0) begin
            an_p0 = '1;
        end

        if (gap_p0 || blink_off_p0) begin
            seg_p0  = SEG_OFF;
            dp_n_p0 = 1'b1;
        end else begin
            seg_p0  = seg_decode(nib_p0, hex_mode);
            dp_n_p0 = ~dp_bit_p0;
        end
    end

    // Stage p1: registered, glitch-free pad drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an   <= '1;
            seg  <= SEG_OFF;
            dp_n <= 1'b1;
        end else begin
            an   <= an_p0;
            seg  <= seg_p0;
            dp_n <= dp_n_p0;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised and directed bench for seven_seg_scanner, checked against an
// arithmetic model built from elapsed-cycle counts.
module tb_seven_seg_scanner;

    localparam int ND    = 4;
    localparam int SDIV  = 4;
    localparam int BLANK = 1;
    localparam int BDIV  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4*ND-1:0] digits = '0;
    logic [ND-1:0] dp_in = '0;
    logic          blink_en = 1'b0;
    logic [ND-1:0] blink_mask = '0;
    logic          hex_mode = 1'b0;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp_n;

    int n_pass = 0;
    int n_checks = 0;

    // Model state: edges since reset release, consecutive blink-enabled edges
    int m_n = 0;
    int m_bk = 0;

    logic [6:0] seg_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_4321 [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};

    seven_seg_scanner #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SDIV),
        .BLANK_CYCLES(BLANK),
        .BLINK_DIV   (BDIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digits    (digits),
        .dp_in     (dp_in),
        .blink_en  (blink_en),
        .blink_mask(blink_mask),
        .hex_mode  (hex_mode),
        .an        (an),
        .seg       (seg),
        .dp_n      (dp_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int cur_slot();
        return (m_n / SDIV) % ND;
    endfunction

    function automatic int cur_pos();
        return m_n % SDIV;
    endfunction

    // Expected registered outputs produced by the coming edge
    task automatic model(output logic [3:0] e_an, output logic [6:0] e_seg, output logic e_dp);
        int   id;
        bit   gap;
        bit   ph;
        bit   dark;
        logic [3:0] nib;
        id   = cur_slot();
        gap  = cur_pos() < BLANK;
        ph   = ((m_bk / BDIV) % 2) == 1;
        dark = gap || (blink_en && ph && blink_mask[id]);
        nib  = 4'((digits >> (4 * id)) & 16'hF);
        e_an = gap ? 4'hF : ~(4'b0001 << id);
        if (dark || (!hex_mode && nib > 4'd9)) e_seg = 7'h7F;
        else                                  e_seg = seg_tbl[nib];
        e_dp = dark ? 1'b1 : ~dp_in[id];
    endtask

    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        model(ea, es, ed);
        @(posedge clk);
        m_n++;
        m_bk = blink_en ? m_bk + 1 : 0;
        #1;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        chk("dp_n", 32'(dp_n), 32'(ed));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        m_n = 0;
        m_bk = 0;

        // Plain scan of 4321 against a literal slot/anode table
        digits = 16'h4321;
        for (int c = 0; c < 32; c++) begin
            int s;
            int p;
            s = (c / SDIV) % ND;
            p = c % SDIV;
            step();
            chk("seq_an", 32'(an), (p == 0) ? 32'hF : 32'(an_seq[s]));
            chk("seq_seg", 32'(seg), (p == 0) ? 32'h7F : 32'(seg_4321[s]));
        end

        // Hex decode toggled mid-run
        digits = 16'hFA50;
        repeat (16) step();
        hex_mode = 1'b1;
        repeat (16) step();

        // Decimal point on slot 2 only
        dp_in = 4'b0100;
        repeat (16) step();
        dp_in = 4'b0000;

        // Blinking of slots 0-1
        digits = 16'h8765;
        blink_mask = 4'b0011;
        blink_en = 1'b1;
        repeat (40) step();
        for (int k = 0; k < 32 && ((m_bk / BDIV) % 2) != 1; k++) step();
        chk("in_phase1", 32'((m_bk / BDIV) % 2), 32'd1);
        blink_en = 1'b0;
        step();
        chk("blink_cnt_clr", 32'(dut.blink_cnt), 32'd0);
        chk("blink_ph_clr", 32'(dut.blink_phase), 32'd0);
        repeat (8) step();

        // Asynchronous reset in the middle of slot 2
        for (int k = 0; k < 32 && !(cur_slot() == 2 && cur_pos() == 2); k++) step();
        rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_dp", 32'(dp_n), 32'h1);
        @(posedge clk);
        #1;
        chk("arst_hold_an", 32'(an), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        m_n = 0;
        m_bk = 0;
        step();
        chk("restart_gap", 32'(an), 32'hF);
        step();
        chk("restart_slot0", 32'(an), 32'hE);

        // Randomised inputs
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) hex_mode = ~hex_mode;
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 47) == 0) blink_en = ~blink_en;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
